// File: rtl/bt_uart_tx.sv
// rtl/bt_uart_tx.sv - UART transmitter (8 data bits, LSB first, optional parity, 1/2 stop bits)
module bt_uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int N        = CLK_FREQ / BAUD;
   localparam int CW       = (N < 2) ? 1 : $clog2(N);
   // Out-of-range parity modes fall back to no parity; anything but 2 stop bits means 1
   localparam int PAR_MODE = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
   localparam int NSTOP    = (STOP_BITS == 2) ? 2 : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [2:0]    STOP_LAST = 3'(NSTOP - 1);

   generate
      if (N < 2) begin : g_bad_divisor
         $error("bt_uart_tx: CLK_FREQ/BAUD must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [2:0]      r_idx;
   logic [2:0]      w_idx_next;
   logic [7:0]      r_data;
   logic            r_tx;
   logic            w_tx_next;
   logic            w_load;
   logic            w_bit_end;

   assign w_bit_end = (r_cnt == CNT_LAST);

   // State, baud counter, bit index, latched byte and the line flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_tx    <= w_tx_next;
         if (w_load) begin
            r_data <= tx_data;
         end
      end
   end

   // Next-state: the counter only advances inside a frame, bit changes happen on its last count
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_load       = 1'b0;
      if (r_state == S_IDLE) begin
         w_cnt_next = '0;
         w_idx_next = '0;
         if (tx_valid) begin
            w_state_next = S_START;
            w_load       = 1'b1;
         end
      end else if (!w_bit_end) begin
         w_cnt_next = r_cnt + CW'(1);
      end else begin
         w_cnt_next = '0;
         case (r_state)
            S_START: begin
               w_state_next = S_DATA;
               w_idx_next   = '0;
            end
            S_DATA: begin
               if (r_idx == 3'd7) begin
                  w_idx_next   = '0;
                  w_state_next = (PAR_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end
            S_PARITY: begin
               w_state_next = S_STOP;
               w_idx_next   = '0;
            end
            S_STOP: begin
               if (r_idx == STOP_LAST) begin
                  w_state_next = S_IDLE;
                  w_idx_next   = '0;
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_idx_next   = '0;
            end
         endcase
      end
   end

   // Outputs: the line level is decoded from the next state so it lands in the flop on the boundary edge
   always_comb begin
      w_tx_next = 1'b1;
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = r_data[w_idx_next];
         S_PARITY: w_tx_next = (PAR_MODE == 1) ? ~^r_data : ^r_data;
         default:  w_tx_next = 1'b1;
      endcase
      tx_ready = (r_state == S_IDLE);
      busy     = (r_state != S_IDLE);
   end

   assign tx = r_tx;

endmodule

// File: tb/tb_bt_uart_tx.sv
// tb/tb_bt_uart_tx.sv - directed self-checking bench for bt_uart_tx
module tb_bt_uart_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic [3:0] v;
   logic [3:0] rdy;
   logic [3:0] txs;
   logic [3:0] bsy;

   int checks;
   int errors;

   logic cap_tx  [0:63];
   logic cap_rdy [0:63];
   logic cap_bsy [0:63];

   // idx 0: no parity, 1 stop; idx 1: even; idx 2: odd; idx 3: 2 stop bits
   bt_uart_tx #(.CLK_FREQ(16), .BAUD(4), .PARITY(0), .STOP_BITS(1)) u_p0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[0]),
      .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
   bt_uart_tx #(.CLK_FREQ(16), .BAUD(4), .PARITY(2), .STOP_BITS(1)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[1]),
      .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
   bt_uart_tx #(.CLK_FREQ(16), .BAUD(4), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[2]),
      .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
   bt_uart_tx #(.CLK_FREQ(16), .BAUD(4), .PARITY(0), .STOP_BITS(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[3]),
      .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

   // Present a byte before the next rising edge; returns just after acceptance edge k
   task automatic accept(input int idx, input logic [7:0] d, input bit hold);
      @(negedge clk);
      tx_data = d;
      v[idx]  = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) v[idx] = 1'b0;
   endtask

   // Record outputs at falling edges; entry off+i holds the state after edge k+off+i
   task automatic capture(input int idx, input int off, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_tx[off+i]  = txs[idx];
         cap_rdy[off+i] = rdy[idx];
         cap_bsy[off+i] = bsy[idx];
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (txs !== 4'hF) begin errors++; $display("FAIL reset_tx got %b exp 1111", txs); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready got %b exp 1111", rdy); end
      checks++;
      if (bsy !== 4'h0) begin errors++; $display("FAIL reset_busy got %b exp 0000", bsy); end
      capture(0, 0, 20);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (cap_tx[i] !== 1'b1) begin errors++; $display("FAIL idle_tx clk %0d got %b exp 1", i, cap_tx[i]); end
      end
   endtask

   task automatic test_single();
      string exp;
      logic  e;
      exp = "0101010101";
      accept(0, 8'h55, 1'b0);
      capture(0, 0, 41);
      for (int i = 0; i < 40; i++) begin
         e = (exp[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL single_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
         checks++;
         if (cap_rdy[i] !== 1'b0 || cap_bsy[i] !== 1'b1) begin
            errors++; $display("FAIL single_hs clk %0d ready %b busy %b exp ready 0 busy 1", i, cap_rdy[i], cap_bsy[i]);
         end
      end
      checks++;
      if (cap_rdy[40] !== 1'b1 || cap_bsy[40] !== 1'b0 || cap_tx[40] !== 1'b1) begin
         errors++; $display("FAIL single_end ready %b busy %b tx %b exp 1 0 1", cap_rdy[40], cap_bsy[40], cap_tx[40]);
      end
   endtask

   task automatic test_parity();
      string exp;
      int    idx;
      logic  e;
      for (int m = 0; m < 2; m++) begin
         // 0xA3 has four ones: even parity bit 0, odd parity bit 1
         idx = (m == 0) ? 1 : 2;
         exp = (m == 0) ? "01100010101" : "01100010111";
         accept(idx, 8'hA3, 1'b0);
         capture(idx, 0, 45);
         for (int i = 0; i < 44; i++) begin
            e = (exp[i/4] == "1");
            checks++;
            if (cap_tx[i] !== e) begin errors++; $display("FAIL parity%0d_tx clk %0d got %b exp %b", m, i, cap_tx[i], e); end
            checks++;
            if (cap_bsy[i] !== 1'b1) begin errors++; $display("FAIL parity%0d_busy clk %0d got %b exp 1", m, i, cap_bsy[i]); end
         end
         checks++;
         if (cap_rdy[44] !== 1'b1 || cap_bsy[44] !== 1'b0) begin
            errors++; $display("FAIL parity%0d_end ready %b busy %b exp 1 0", m, cap_rdy[44], cap_bsy[44]);
         end
      end
   endtask

   task automatic test_back_to_back();
      string exp1;
      string exp2;
      logic  e;
      exp1 = "0000000001";
      exp2 = "0111111111";
      accept(0, 8'h00, 1'b1);
      capture(0, 0, 41);
      for (int i = 0; i < 40; i++) begin
         e = (exp1[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL b2b_first_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
      end
      checks++;
      if (cap_tx[40] !== 1'b1 || cap_bsy[40] !== 1'b0 || cap_rdy[40] !== 1'b1) begin
         errors++; $display("FAIL b2b_gap tx %b busy %b ready %b exp 1 0 1", cap_tx[40], cap_bsy[40], cap_rdy[40]);
      end
      tx_data = 8'hFF;
      capture(0, 0, 40);
      for (int i = 0; i < 40; i++) begin
         e = (exp2[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL b2b_second_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
         checks++;
         if (cap_bsy[i] !== 1'b1) begin errors++; $display("FAIL b2b_second_busy clk %0d got %b exp 1", i, cap_bsy[i]); end
      end
      v[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || txs[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_end ready %b busy %b tx %b exp 1 0 1", rdy[0], bsy[0], txs[0]);
      end
   endtask

   task automatic test_two_stop();
      string exp;
      logic  e;
      exp = "00000000111";
      accept(3, 8'h80, 1'b1);
      capture(3, 0, 46);
      for (int i = 0; i < 44; i++) begin
         e = (exp[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL stop2_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
         checks++;
         if (cap_bsy[i] !== 1'b1) begin errors++; $display("FAIL stop2_busy clk %0d got %b exp 1", i, cap_bsy[i]); end
      end
      checks++;
      if (cap_bsy[44] !== 1'b0 || cap_tx[44] !== 1'b1) begin
         errors++; $display("FAIL stop2_end busy %b tx %b exp 0 1", cap_bsy[44], cap_tx[44]);
      end
      checks++;
      if (cap_bsy[45] !== 1'b1 || cap_tx[45] !== 1'b0) begin
         errors++; $display("FAIL stop2_next busy %b tx %b exp 1 0", cap_bsy[45], cap_tx[45]);
      end
      v[3] = 1'b0;
      repeat (50) @(negedge clk);
   endtask

   task automatic test_data_change();
      string exp;
      logic  e;
      exp = "0111100001";
      accept(0, 8'h0F, 1'b0);
      capture(0, 0, 6);
      tx_data = 8'hFF;
      capture(0, 6, 35);
      for (int i = 0; i < 40; i++) begin
         e = (exp[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL hold_data_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
      end
      checks++;
      if (cap_bsy[40] !== 1'b0) begin errors++; $display("FAIL hold_data_end busy %b exp 0", cap_bsy[40]); end
      tx_data = 8'h00;
   endtask

   task automatic test_reset_mid_frame();
      string exp;
      logic  e;
      accept(0, 8'h00, 1'b0);
      capture(0, 0, 17);
      checks++;
      if (cap_tx[16] !== 1'b0) begin errors++; $display("FAIL abort_pre tx %b exp 0", cap_tx[16]); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (txs[0] !== 1'b1) begin errors++; $display("FAIL abort_tx got %b exp 1", txs[0]); end
      checks++;
      if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         errors++; $display("FAIL abort_hs busy %b ready %b exp 0 1", bsy[0], rdy[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp = "0100000001";
      accept(0, 8'h01, 1'b0);
      capture(0, 0, 41);
      for (int i = 0; i < 40; i++) begin
         e = (exp[i/4] == "1");
         checks++;
         if (cap_tx[i] !== e) begin errors++; $display("FAIL after_abort_tx clk %0d got %b exp %b", i, cap_tx[i], e); end
      end
      checks++;
      if (cap_bsy[40] !== 1'b0 || cap_rdy[40] !== 1'b1) begin
         errors++; $display("FAIL after_abort_end busy %b ready %b exp 0 1", cap_bsy[40], cap_rdy[40]);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      tx_data = 8'h00;
      v       = 4'h0;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_two_stop();
      test_data_change();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
